// File: rtl/serial_rx_deser_if.sv
// Receive-side handshake bundle for serial_rx_deser: the parallel word, its
// valid/ready pair and the status flags.
interface serial_rx_deser_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] rxData;
  logic             rxValid;
  logic             rxReady;
  logic             rxErr;
  logic             rxOvr;
  logic             rxBusy;

  modport master (
    output rxData,
    output rxValid,
    output rxErr,
    output rxOvr,
    output rxBusy,
    input  rxReady
  );

  modport slave (
    input  rxData,
    input  rxValid,
    input  rxErr,
    input  rxOvr,
    input  rxBusy,
    output rxReady
  );
endinterface

// File: rtl/serial_rx_deser.sv
// Rebuilds DataOut/clkTx/DOutValid serial frames into parallel words behind a
// valid/ready holding register. Optional frame counter: SERIAL_RX_FRAME_CNT_EN.
module serial_rx_deser #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic DOutValid,
  input  logic DataOut,
  input  logic clkTx,
  serial_rx_deser_if.master rxIf
`ifdef SERIAL_RX_FRAME_CNT_EN
  ,
  output logic [15:0] frameCnt
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    TAIL
  } StateT;

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH);

  StateT            state;
  logic             vQ;
  logic             dQ;
  logic             cQ;
  logic             cQQ;
  logic             primed;
  logic             armed;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-2:0] sh;

  logic             bitStb;
  logic [WIDTH-1:0] shNext;
  logic [CNT_W-1:0] cntNext;
  logic             frameDone;
  logic             canLoad;

  assign bitStb    = cQ & ~cQQ;
  assign shNext    = {sh, dQ};
  assign cntNext   = cnt + 1'b1;
  assign frameDone = (state == SHIFT) && bitStb && (cntNext == LastCnt);
  assign canLoad   = !rxIf.rxValid || rxIf.rxReady;

  // primed marks that vQ holds a real sample; armed then waits for vQ low so a
  // frame already in flight when reset releases is never picked up halfway.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      vQ           <= 1'b0;
      dQ           <= 1'b0;
      cQ           <= 1'b0;
      cQQ          <= 1'b0;
      primed       <= 1'b0;
      armed        <= 1'b0;
      cnt          <= '0;
      sh           <= '0;
      rxIf.rxData  <= '0;
      rxIf.rxValid <= 1'b0;
      rxIf.rxErr   <= 1'b0;
      rxIf.rxOvr   <= 1'b0;
      rxIf.rxBusy  <= 1'b0;
`ifdef SERIAL_RX_FRAME_CNT_EN
      frameCnt     <= '0;
`endif
    end else begin
      vQ     <= DOutValid;
      dQ     <= DataOut;
      cQ     <= clkTx;
      cQQ    <= cQ;
      primed <= 1'b1;
      if (primed && !vQ) begin
        armed <= 1'b1;
      end
      rxIf.rxErr <= 1'b0;

      if (rxIf.rxValid && rxIf.rxReady) begin
        rxIf.rxValid <= 1'b0;
        rxIf.rxOvr   <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (vQ && armed) begin
            state       <= SHIFT;
            rxIf.rxBusy <= 1'b1;
            if (bitStb) begin
              sh  <= shNext[WIDTH-2:0];
              cnt <= CNT_W'(1);
            end
          end
        end

        SHIFT: begin
          if (frameDone) begin
            state <= TAIL;
            cnt   <= '0;
            if (canLoad) begin
              rxIf.rxData  <= shNext;
              rxIf.rxValid <= 1'b1;
`ifdef SERIAL_RX_FRAME_CNT_EN
              frameCnt     <= frameCnt + 16'd1;
`endif
            end else begin
              rxIf.rxOvr <= 1'b1;
            end
          end else begin
            if (bitStb) begin
              sh  <= shNext[WIDTH-2:0];
              cnt <= cntNext;
            end
            // Any bit on this cycle was taken above; the frame is still short.
            if (!vQ) begin
              rxIf.rxErr  <= 1'b1;
              state       <= IDLE;
              rxIf.rxBusy <= 1'b0;
              cnt         <= '0;
            end
          end
        end

        TAIL: begin
          if (bitStb) begin
            rxIf.rxErr <= 1'b1;
          end
          if (!vQ) begin
            state       <= IDLE;
            rxIf.rxBusy <= 1'b0;
          end
        end

        default: begin
          state       <= IDLE;
          rxIf.rxBusy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_rx_deser.sv
// Directed self-checking bench for serial_rx_deser; frame counter checks run
// only when SERIAL_RX_FRAME_CNT_EN is defined.
module tb_serial_rx_deser;

  logic clk;
  logic reset;
  logic DOutValid;
  logic DataOut;
  logic clkTx;
`ifdef SERIAL_RX_FRAME_CNT_EN
  logic [15:0] frameCnt;
`endif

  int checks;
  int failures;
  int validCycles;
  int errPulses;
  logic [31:0] capData;

  serial_rx_deser_if #(.WIDTH(32)) rxIf ();

  serial_rx_deser #(
    .WIDTH(32),
    .CNT_W(6)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .DOutValid(DOutValid),
    .DataOut  (DataOut),
    .clkTx    (clkTx),
    .rxIf     (rxIf)
`ifdef SERIAL_RX_FRAME_CNT_EN
    ,
    .frameCnt (frameCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are observed on the falling edge, half a period after they settle.
  always @(negedge clk) begin
    if (rxIf.rxValid) begin
      validCycles = validCycles + 1;
      capData     = rxIf.rxData;
    end
    if (rxIf.rxErr) begin
      errPulses = errPulses + 1;
    end
  end

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp)
    else begin
      failures = failures + 1;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clearCounters();
    validCycles = 0;
    errPulses   = 0;
    capData     = 32'hDEAD_BEEF;
  endtask

  // clkTx runs at clk/4: two low cycles with DataOut settled, two high.
  task automatic sendBit(input logic b);
    DataOut = b;
    clkTx   = 1'b0;
    waitCycles(2);
    clkTx   = 1'b1;
    waitCycles(2);
  endtask

  task automatic applyStimulus(input logic [63:0] bits, input int nbits);
    logic [63:0] word;
    word      = bits;
    DOutValid = 1'b1;
    for (int i = nbits - 1; i >= 0; i--) sendBit(word[i]);
    clkTx = 1'b0;
    waitCycles(2);
    DOutValid = 1'b0;
    waitCycles(4);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b0;
    DOutValid = 1'b0;
    DataOut   = 1'b0;
    clkTx     = 1'b0;
    rxIf.rxReady = 1'b0;
    clearCounters();

    waitCycles(3);
    checkOutput("reset_rxData", rxIf.rxData, 32'h0);
    checkOutput("reset_rxValid", {31'b0, rxIf.rxValid}, 32'h0);
    checkOutput("reset_rxErr", {31'b0, rxIf.rxErr}, 32'h0);
    checkOutput("reset_rxOvr", {31'b0, rxIf.rxOvr}, 32'h0);
    checkOutput("reset_rxBusy", {31'b0, rxIf.rxBusy}, 32'h0);
    reset = 1'b1;
    waitCycles(3);

    rxIf.rxReady = 1'b1;
    clearCounters();
    applyStimulus({32'h0, 32'h0000_0002}, 32);
    checkOutput("nom_validCycles", validCycles, 32'd1);
    checkOutput("nom_data", capData, 32'h0000_0002);
    checkOutput("nom_errPulses", errPulses, 32'd0);
    checkOutput("nom_busyAfter", {31'b0, rxIf.rxBusy}, 32'h0);
    checkOutput("nom_validAfter", {31'b0, rxIf.rxValid}, 32'h0);

    rxIf.rxReady = 1'b0;
    applyStimulus({32'h0, 32'hA5A5_00FF}, 32);
    checkOutput("held_valid", {31'b0, rxIf.rxValid}, 32'h1);
    checkOutput("held_data", rxIf.rxData, 32'hA5A5_00FF);
    checkOutput("held_ovrClear", {31'b0, rxIf.rxOvr}, 32'h0);
    applyStimulus({32'h0, 32'h1234_5678}, 32);
    checkOutput("ovr_flag", {31'b0, rxIf.rxOvr}, 32'h1);
    checkOutput("ovr_dataKept", rxIf.rxData, 32'hA5A5_00FF);
    checkOutput("ovr_valid", {31'b0, rxIf.rxValid}, 32'h1);
    rxIf.rxReady = 1'b1;
    waitCycles(1);
    rxIf.rxReady = 1'b0;
    checkOutput("hs_validCleared", {31'b0, rxIf.rxValid}, 32'h0);
    checkOutput("hs_ovrCleared", {31'b0, rxIf.rxOvr}, 32'h0);
    checkOutput("hs_dataKept", rxIf.rxData, 32'hA5A5_00FF);

    rxIf.rxReady = 1'b1;
    clearCounters();
    applyStimulus({44'h0, 20'hABCDE}, 20);
    checkOutput("short_errPulses", errPulses, 32'd1);
    checkOutput("short_validCycles", validCycles, 32'd0);
    checkOutput("short_busy", {31'b0, rxIf.rxBusy}, 32'h0);
    clearCounters();
    applyStimulus({32'h0, 32'hFFFF_FFFF}, 32);
    checkOutput("afterShort_data", capData, 32'hFFFF_FFFF);
    checkOutput("afterShort_validCycles", validCycles, 32'd1);
    checkOutput("afterShort_errPulses", errPulses, 32'd0);

    clearCounters();
    applyStimulus({30'h0, 32'hC3C3_1234, 2'b10}, 34);
    checkOutput("long_data", capData, 32'hC3C3_1234);
    checkOutput("long_errPulses", errPulses, 32'd2);
    checkOutput("long_validCycles", validCycles, 32'd1);
`ifdef SERIAL_RX_FRAME_CNT_EN
    checkOutput("frameCnt_beforeReset", {16'h0, frameCnt}, 32'd4);
`endif

    clearCounters();
    DOutValid = 1'b1;
    for (int i = 0; i < 10; i++) sendBit(i[0]);
    checkOutput("mid_busyBefore", {31'b0, rxIf.rxBusy}, 32'h1);
    clkTx = 1'b0;
    reset = 1'b0;
    waitCycles(2);
    checkOutput("mid_rxData", rxIf.rxData, 32'h0);
    checkOutput("mid_rxValid", {31'b0, rxIf.rxValid}, 32'h0);
    checkOutput("mid_rxBusy", {31'b0, rxIf.rxBusy}, 32'h0);
    reset = 1'b1;
    for (int i = 0; i < 22; i++) sendBit(i[1]);
    checkOutput("mid_ignoredBusy", {31'b0, rxIf.rxBusy}, 32'h0);
    clkTx = 1'b0;
    waitCycles(2);
    DOutValid = 1'b0;
    waitCycles(4);
    checkOutput("mid_ignoredValid", validCycles, 32'd0);
    checkOutput("mid_ignoredErr", errPulses, 32'd0);
    applyStimulus({32'h0, 32'h0000_00FF}, 32);
    checkOutput("postReset_data", capData, 32'h0000_00FF);
    checkOutput("postReset_validCycles", validCycles, 32'd1);
`ifdef SERIAL_RX_FRAME_CNT_EN
    checkOutput("frameCnt_afterReset", {16'h0, frameCnt}, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
